sdram_apb_csr_mp: RTL and testbench
===================================

SDRAM_APB_CSR_MP -- requirements
Module: sdram_apb_csr_mp

Interface
REQ-001 SHALL have parameter PORTS, default 4, number of AHB ports with a per-port config register (1..8).
REQ-002 SHALL have parameter PADDR_SIZE, default 6, APB address width.
REQ-003 SHALL have parameter PDATA_SIZE, default 32, APB data width (fixed 32).
REQ-004 SHALL have parameter INIT_DLY_CNT, default 2500, power-up delay in PCLK cycles.
REQ-005 SHALL have parameter UPD_TIMEOUT, default 255, max cycles to wait for upd_ack_i.
REQ-006 SHALL have ports, each as name  direction  width  meaning:
- PCLK  in  1  clock
- PRESET  in  1  reset
- PSEL  in  1  select
- PENABLE  in  1  access phase
- PADDR  in  PADDR_SIZE  byte address
- PWRITE  in  1  write
- PSTRB  in  4  byte strobes
- PPROT  in  3  protection
- PWDATA  in  32  write data
- PRDATA  out  32  read data
- PREADY  out  1  ready
- PSLVERR  out  1  error
- csr_ctrl_o  out  32  active CTRL
- csr_timing_o  out  32  active TIMING
- csr_tref_o  out  16  active TREF
- port_cfg_o  out  PORTS*16  active PORTCFG, port p at [16p+:16]
- upd_req_o  out  1  update request to controller
- upd_ack_i  in  1  controller idle, accept update
- init_done_o  out  1  power-up delay elapsed
REQ-007 SHALL use one clock; reset is asynchronous and active-high (PCLK, PRESET).

Function
REQ-008 Address map SHALL be: 0x00 CTRL, 0x04 TIMING, 0x08 TREF (bits 15:0), 0x0C STATUS (RO: bit0 upd_req_o, bit1 init_done_o, bit2 last update timed out), 0x10+4p PORTCFG[p] (bits 15:0), p<PORTS.
REQ-009 Any other address, a write to STATUS, or p>=PORTS SHALL give PSLVERR=1 with PREADY=1 in the access phase and no register change.
REQ-010 PRDATA SHALL be registered on the setup phase (PSEL & !PENABLE & !PWRITE); reads complete with zero wait states.
REQ-011 Reads of CTRL, TIMING, TREF and PORTCFG SHALL return the shadow value; CTRL[30] SHALL read init_done_o.
REQ-012 Legal writes SHALL update shadow bytes per PSTRB at the setup-phase edge; CTRL[31] SHALL be masked to 0 while init_done_o=0.
REQ-013 The update FSM SHALL have states IDLE, REQ, DONE.
- IDLE: on a legal write setup, go to REQ; PREADY<=0; upd_req_o<=1; timer<=0.
- REQ: when upd_ack_i=1, all active outputs <= shadow, upd_req_o<=0, PREADY<=1, PSLVERR<=0, go to DONE.
- REQ, timeout: if timer==UPD_TIMEOUT with no ack, upd_req_o<=0, PREADY<=1, PSLVERR<=1, set STATUS[2], go to DONE; active outputs unchanged.
- DONE: go to IDLE when PENABLE=0.
REQ-014 A successful update SHALL clear STATUS[2].
REQ-015 upd_ack_i while upd_req_o=0 SHALL be ignored.
REQ-016 init counter SHALL load INIT_DLY_CNT, decrement each cycle, and set init_done_o when it reaches 0; init_done_o stays 1 until reset.
REQ-017 Timer width SHALL be $clog2(UPD_TIMEOUT+1); the timer SHALL saturate at UPD_TIMEOUT (no wrap).

Reset
REQ-018 While PRESET=1: PREADY=1, PSLVERR=0, upd_req_o=0, init_done_o=0, FSM=IDLE, STATUS[2]=0, PRDATA=0.
REQ-019 While PRESET=1: shadow and active CTRL/TIMING=0, TREF=128, PORTCFG=0.
REQ-020 Reset mid-update SHALL abort the request with no output transfer.

Configuration
REQ-021 With SDRAM_CSR_PROT_EN defined, CTRL[29] is privilege-protect; when set, any access with PPROT[0]=0 SHALL give PSLVERR=1, PREADY=1 and no write.
REQ-022 Without SDRAM_CSR_PROT_EN, CTRL[29] SHALL read 0 and ignore writes, and PPROT SHALL be ignored.

Verification
REQ-023 Reset, wait INIT_DLY_CNT+1 cycles -> init_done_o=1; CTRL read returns 0x4000_0000.
REQ-024 Write TIMING=0x1234_5678, ack 3 cycles after upd_req_o -> PREADY low 4 cycles; csr_timing_o=0x1234_5678 on PREADY rise.
REQ-025 Write TREF with PSTRB=0x1, data 0x00FF, ack 1 cycle after upd_req_o -> csr_tref_o=0x00FF (upper byte stays 0x00).
REQ-026 Write PORTCFG[2]=0xA5A5, ack held 0 -> after UPD_TIMEOUT cycles PSLVERR=1; port_cfg_o unchanged; STATUS reads 0x6.
REQ-027 Write to 0x10+4*PORTS or to 0x0C -> PSLVERR=1, zero wait states, upd_req_o stays 0.
REQ-028 With SDRAM_CSR_PROT_EN, set CTRL[29]=1, then user write (PPROT=0) to TIMING -> PSLVERR=1, TIMING unchanged.

Source files
------------

// File: rtl/sdram_apb_csr_mp.sv
// sdram_apb_csr_mp: APB CSR block with shadow/active SDRAM config and handshaked update to the controller.
// Optional: define SDRAM_CSR_PROT_EN to make CTRL[29] a privilege-protect bit.
module sdram_apb_csr_mp #(
  parameter int PORTS        = 4,
  parameter int PADDR_SIZE   = 6,
  parameter int PDATA_SIZE   = 32,
  parameter int INIT_DLY_CNT = 2500,
  parameter int UPD_TIMEOUT  = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [PADDR_SIZE-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [3:0]            PSTRB,
  input  logic [2:0]            PPROT,
  input  logic [PDATA_SIZE-1:0] PWDATA,
  output logic [PDATA_SIZE-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [31:0]           csr_ctrl_o,
  output logic [31:0]           csr_timing_o,
  output logic [15:0]           csr_tref_o,
  output logic [PORTS*16-1:0]   port_cfg_o,
  output logic                  upd_req_o,
  input  logic                  upd_ack_i,
  output logic                  init_done_o
);
  localparam int TW = UPD_TIMEOUT > 0 ? $clog2(UPD_TIMEOUT + 1) : 1;
  localparam int IW = INIT_DLY_CNT > 0 ? $clog2(INIT_DLY_CNT + 1) : 1;
  localparam int AW = PADDR_SIZE - 2;
  localparam logic [TW-1:0] TMAX = TW'(UPD_TIMEOUT);
  localparam logic [AW-1:0] PN = AW'(PORTS);
  localparam logic [AW-1:0] W_CTRL = AW'(0);
  localparam logic [AW-1:0] W_TIMING = AW'(1);
  localparam logic [AW-1:0] W_TREF = AW'(2);
  localparam logic [AW-1:0] W_STATUS = AW'(3);
  localparam logic [AW-1:0] W_CFG = AW'(4);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state;
  logic [31:0] sh_ctrl, sh_timing, wm_ctrl, wm_timing, rdata;
  logic [15:0] sh_tref, cfg_rd, wm_tref, wm_cfg;
  logic [PORTS*16-1:0] sh_cfg;
  logic [TW-1:0] timer;
  logic [IW-1:0] init_cnt;
  logic [AW-1:0] word, pw;
  logic upd_to, setup, accept, aligned, is_ctrl, is_timing, is_tref, is_status, is_cfg, prot_block, reg_ok;
  function automatic logic [15:0] merge16(input logic [15:0] old, input logic [15:0] d, input logic [1:0] s);
    return {s[1] ? d[15:8] : old[15:8], s[0] ? d[7:0] : old[7:0]};
  endfunction
  function automatic logic [31:0] merge32(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    return {merge16(old[31:16], d[31:16], s[3:2]), merge16(old[15:0], d[15:0], s[1:0])};
  endfunction
`ifdef SDRAM_CSR_PROT_EN
  localparam logic [31:0] CTRL_WMASK = 32'hBFFF_FFFF;
  assign prot_block = sh_ctrl[29] & ~PPROT[0];
`else
  localparam logic [31:0] CTRL_WMASK = 32'h9FFF_FFFF;
  assign prot_block = 1'b0;
`endif
  logic unused_prot;
  assign unused_prot = ^PPROT;
  assign word = PADDR[PADDR_SIZE-1:2];
  assign pw = word - W_CFG;
  assign aligned = PADDR[1:0] == 2'b00;
  assign setup = PSEL & ~PENABLE;
  assign accept = state == IDLE || (state == DONE && !PENABLE);
  assign is_ctrl = aligned && word == W_CTRL;
  assign is_timing = aligned && word == W_TIMING;
  assign is_tref = aligned && word == W_TREF;
  assign is_status = aligned && word == W_STATUS;
  assign is_cfg = aligned && word >= W_CFG && pw < PN;
  assign reg_ok = (is_ctrl | is_timing | is_tref | is_status | is_cfg) & ~(PWRITE & is_status) & ~prot_block;
  always_comb begin
    cfg_rd = '0;
    for (int p = 0; p < PORTS; p++) cfg_rd = pw == AW'(p) ? sh_cfg[16*p+:16] : cfg_rd;
  end
  // bit 30 is never stored: it mirrors init_done_o on read; bit 31 stays 0 until power-up delay ends
  assign wm_ctrl = merge32(sh_ctrl, PWDATA, PSTRB) & CTRL_WMASK & {init_done_o, 31'h7FFF_FFFF};
  assign wm_timing = merge32(sh_timing, PWDATA, PSTRB);
  assign wm_tref = merge16(sh_tref, PWDATA[15:0], PSTRB[1:0]);
  assign wm_cfg = merge16(cfg_rd, PWDATA[15:0], PSTRB[1:0]);
  assign rdata = is_ctrl ? (sh_ctrl | {1'b0, init_done_o, 30'b0}) :
                 is_timing ? sh_timing :
                 is_tref ? {16'b0, sh_tref} :
                 is_status ? {29'b0, upd_to, init_done_o, upd_req_o} :
                 is_cfg ? {16'b0, cfg_rd} : '0;
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      init_cnt <= IW'(INIT_DLY_CNT);
      init_done_o <= 1'b0;
    end else if (init_cnt != '0) init_cnt <= init_cnt - 1'b1;
    else init_done_o <= 1'b1;
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      state <= IDLE;
      PREADY <= 1'b1;
      PSLVERR <= 1'b0;
      PRDATA <= '0;
      upd_req_o <= 1'b0;
      upd_to <= 1'b0;
      timer <= '0;
      sh_ctrl <= '0;
      sh_timing <= '0;
      sh_tref <= 16'd128;
      sh_cfg <= '0;
      csr_ctrl_o <= '0;
      csr_timing_o <= '0;
      csr_tref_o <= 16'd128;
      port_cfg_o <= '0;
    end else if (accept) begin
      state <= IDLE;
      if (setup) begin
        PSLVERR <= ~reg_ok;
        if (!PWRITE) PRDATA <= reg_ok ? rdata : '0;
        if (PWRITE && reg_ok) begin
          state <= REQ;
          PREADY <= 1'b0;
          upd_req_o <= 1'b1;
          timer <= '0;
          if (is_ctrl) sh_ctrl <= wm_ctrl;
          if (is_timing) sh_timing <= wm_timing;
          if (is_tref) sh_tref <= wm_tref;
          for (int p = 0; p < PORTS; p++)
            if (is_cfg && pw == AW'(p)) sh_cfg[16*p+:16] <= wm_cfg;
        end
      end
    end else if (state == REQ) begin
      if (upd_ack_i) begin
        csr_ctrl_o <= sh_ctrl;
        csr_timing_o <= sh_timing;
        csr_tref_o <= sh_tref;
        port_cfg_o <= sh_cfg;
        upd_req_o <= 1'b0;
        upd_to <= 1'b0;
        PREADY <= 1'b1;
        PSLVERR <= 1'b0;
        state <= DONE;
      end else if (timer == TMAX) begin
        upd_req_o <= 1'b0;
        upd_to <= 1'b1;
        PREADY <= 1'b1;
        PSLVERR <= 1'b1;
        state <= DONE;
      end else timer <= timer + 1'b1;
    end
endmodule

// File: tb/tb_sdram_apb_csr_mp.sv
// tb_sdram_apb_csr_mp: table-driven APB vectors with a scoreboard queue, plus hand sequences for
// reset abort, power-up delay, stray ack and the optional privilege protect.
module tb_sdram_apb_csr_mp;
  localparam int INIT = 2500;
  localparam int TO = 255;
`ifdef SDRAM_CSR_PROT_EN
  localparam logic [31:0] EARLY_CTRL = 32'h3FFF_FFFF;
`else
  localparam logic [31:0] EARLY_CTRL = 32'h1FFF_FFFF;
`endif
  typedef struct {
    logic wr; logic [5:0] a; logic [31:0] d; logic [3:0] s; int dly;
    logic [31:0] rd; logic err; int waits;
    logic [31:0] ctrl; logic [31:0] timing; logic [15:0] tref; logic [63:0] cfg;
  } vec_t;
  typedef struct { logic wr; logic [31:0] rd; logic err; int waits; } exp_t;
  logic PCLK = 0, PRESET = 1, PSEL = 0, PENABLE = 0, PWRITE = 0;
  logic [5:0] PADDR = '0;
  logic [3:0] PSTRB = '0;
  logic [2:0] PPROT = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA, csr_ctrl, csr_timing;
  logic [15:0] csr_tref;
  logic [63:0] port_cfg;
  logic PREADY, PSLVERR, upd_req, init_done, upd_ack;
  logic ack_auto = 0, ack_force = 0;
  int ack_dly = -1, ack_n = 0, errors = 0, checks = 0;
  exp_t sb[$];
  assign upd_ack = ack_auto | ack_force;
  sdram_apb_csr_mp dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PSTRB(PSTRB), .PPROT(PPROT), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .csr_ctrl_o(csr_ctrl), .csr_timing_o(csr_timing), .csr_tref_o(csr_tref), .port_cfg_o(port_cfg),
    .upd_req_o(upd_req), .upd_ack_i(upd_ack), .init_done_o(init_done)
  );
  always #5 PCLK = ~PCLK;
  // controller model: raises ack ack_dly cycles after it first sees upd_req (-1 = never)
  always @(negedge PCLK)
    if (!upd_req) begin
      ack_auto = 0;
      ack_n = 0;
    end else begin
      if (ack_n == ack_dly) ack_auto = 1;
      ack_n++;
    end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic apb(input logic wr, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [2:0] pr, output logic [31:0] rd, output logic err, output int waits);
    @(negedge PCLK);
    PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = a; PWDATA = d; PSTRB = s; PPROT = pr;
    @(negedge PCLK);
    PENABLE = 1;
    waits = 0;
    while (!PREADY && waits < 1000) begin
      @(negedge PCLK);
      waits++;
    end
    if (!PREADY) chk("pready_bound", 64'(PREADY), 64'd1);
    rd = PRDATA;
    err = PSLVERR;
    @(posedge PCLK);
    #1;
    PSEL = 0; PENABLE = 0;
  endtask
  function automatic vec_t mk(logic wr, logic [5:0] a, logic [31:0] d, logic [3:0] s, int dly,
                              logic [31:0] rd, logic err, int waits,
                              logic [31:0] c, logic [31:0] t, logic [15:0] r, logic [63:0] g);
    vec_t v;
    v.wr = wr; v.a = a; v.d = d; v.s = s; v.dly = dly; v.rd = rd; v.err = err; v.waits = waits;
    v.ctrl = c; v.timing = t; v.tref = r; v.cfg = g;
    return v;
  endfunction
  initial begin
    logic [31:0] rd;
    logic err;
    int w;
    exp_t e;
    vec_t tv[$];
    tv.push_back(mk(0, 6'h00, 0, 4'hF, 0, 32'h4000_0000, 0, 0, 0, 0, 16'h0080, 0));
    tv.push_back(mk(0, 6'h08, 0, 4'hF, 0, 32'h0000_0080, 0, 0, 0, 0, 16'h0080, 0));
    tv.push_back(mk(0, 6'h0C, 0, 4'hF, 0, 32'h2, 0, 0, 0, 0, 16'h0080, 0));
    tv.push_back(mk(1, 6'h04, 32'h1234_5678, 4'hF, 3, 0, 0, 4, 0, 32'h1234_5678, 16'h0080, 0));
    tv.push_back(mk(0, 6'h04, 0, 4'hF, 0, 32'h1234_5678, 0, 0, 0, 32'h1234_5678, 16'h0080, 0));
    tv.push_back(mk(1, 6'h08, 32'h0000_00FF, 4'h1, 1, 0, 0, 2, 0, 32'h1234_5678, 16'h00FF, 0));
    tv.push_back(mk(0, 6'h08, 0, 4'hF, 0, 32'h0000_00FF, 0, 0, 0, 32'h1234_5678, 16'h00FF, 0));
    tv.push_back(mk(1, 6'h18, 32'h0000_A5A5, 4'h3, -1, 0, 1, TO + 1, 0, 32'h1234_5678, 16'h00FF, 0));
    tv.push_back(mk(0, 6'h0C, 0, 4'hF, 0, 32'h6, 0, 0, 0, 32'h1234_5678, 16'h00FF, 0));
    tv.push_back(mk(0, 6'h18, 0, 4'hF, 0, 32'h0000_A5A5, 0, 0, 0, 32'h1234_5678, 16'h00FF, 0));
    tv.push_back(mk(1, 6'h14, 32'h0000_1111, 4'h3, 0, 0, 0, 1, 0, 32'h1234_5678, 16'h00FF, 64'h0000_A5A5_1111_0000));
    tv.push_back(mk(0, 6'h0C, 0, 4'hF, 0, 32'h2, 0, 0, 0, 32'h1234_5678, 16'h00FF, 64'h0000_A5A5_1111_0000));
    tv.push_back(mk(1, 6'h20, 32'h1, 4'hF, 0, 0, 1, 0, 0, 32'h1234_5678, 16'h00FF, 64'h0000_A5A5_1111_0000));
    tv.push_back(mk(1, 6'h0C, 32'h7, 4'hF, 0, 0, 1, 0, 0, 32'h1234_5678, 16'h00FF, 64'h0000_A5A5_1111_0000));
    tv.push_back(mk(0, 6'h30, 0, 4'hF, 0, 0, 1, 0, 0, 32'h1234_5678, 16'h00FF, 64'h0000_A5A5_1111_0000));
    tv.push_back(mk(1, 6'h04, 32'hAAAA_5555, 4'hC, 2, 0, 0, 3, 0, 32'hAAAA_5678, 16'h00FF, 64'h0000_A5A5_1111_0000));
    tv.push_back(mk(1, 6'h00, 32'hDFFF_FFFF, 4'hF, 0, 0, 0, 1, 32'h9FFF_FFFF, 32'hAAAA_5678, 16'h00FF, 64'h0000_A5A5_1111_0000));
    tv.push_back(mk(0, 6'h00, 0, 4'hF, 0, 32'hDFFF_FFFF, 0, 0, 32'h9FFF_FFFF, 32'hAAAA_5678, 16'h00FF, 64'h0000_A5A5_1111_0000));
    tv.push_back(mk(0, 6'h1C, 0, 4'hF, 0, 0, 0, 0, 32'h9FFF_FFFF, 32'hAAAA_5678, 16'h00FF, 64'h0000_A5A5_1111_0000));
    tv.push_back(mk(1, 6'h04, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, 1, 32'h9FFF_FFFF, 32'hAAAA_5678, 16'h00FF, 64'h0000_A5A5_1111_0000));
    tv.push_back(mk(0, 6'h05, 0, 4'hF, 0, 0, 1, 0, 32'h9FFF_FFFF, 32'hAAAA_5678, 16'h00FF, 64'h0000_A5A5_1111_0000));
    repeat (2) @(negedge PCLK);
    chk("rst_pready", 64'(PREADY), 64'd1);
    chk("rst_pslverr", 64'(PSLVERR), 64'd0);
    chk("rst_upd_req", 64'(upd_req), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_prdata", 64'(PRDATA), 64'd0);
    chk("rst_ctrl", 64'(csr_ctrl), 64'd0);
    chk("rst_timing", 64'(csr_timing), 64'd0);
    chk("rst_tref", 64'(csr_tref), 64'd128);
    chk("rst_cfg", port_cfg, 64'd0);
    PRESET = 0;
    ack_dly = 0;
    apb(1, 6'h00, 32'hFFFF_FFFF, 4'hF, 3'b001, rd, err, w);
    chk("early_ctrl_err", 64'(err), 64'd0);
    chk("early_ctrl_out", 64'(csr_ctrl), 64'(EARLY_CTRL));
    apb(0, 6'h00, 32'h0, 4'hF, 3'b001, rd, err, w);
    chk("early_ctrl_rd", 64'(rd), 64'(EARLY_CTRL));
    ack_dly = -1;
    @(negedge PCLK);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 6'h04; PWDATA = 32'hDEAD_BEEF; PSTRB = 4'hF; PPROT = 3'b001;
    @(negedge PCLK);
    PENABLE = 1;
    repeat (3) @(negedge PCLK);
    chk("mid_upd_req", 64'(upd_req), 64'd1);
    chk("mid_pready", 64'(PREADY), 64'd0);
    PRESET = 1;
    #1;
    chk("abort_upd_req", 64'(upd_req), 64'd0);
    chk("abort_pready", 64'(PREADY), 64'd1);
    chk("abort_timing", 64'(csr_timing), 64'd0);
    chk("abort_ctrl", 64'(csr_ctrl), 64'd0);
    chk("abort_prdata", 64'(PRDATA), 64'd0);
    @(negedge PCLK);
    PSEL = 0; PENABLE = 0; PPROT = 0;
    @(negedge PCLK);
    PRESET = 0;
    repeat (INIT) @(posedge PCLK);
    #1 chk("init_before", 64'(init_done), 64'd0);
    @(posedge PCLK);
    #1 chk("init_done", 64'(init_done), 64'd1);
    foreach (tv[i]) begin
      ack_dly = tv[i].dly;
      sb.push_back('{tv[i].wr, tv[i].rd, tv[i].err, tv[i].waits});
      apb(tv[i].wr, tv[i].a, tv[i].d, tv[i].s, 3'b000, rd, err, w);
      e = sb.pop_front();
      if (!e.wr) chk($sformatf("v%0d_prdata", i), 64'(rd), 64'(e.rd));
      chk($sformatf("v%0d_pslverr", i), 64'(err), 64'(e.err));
      chk($sformatf("v%0d_waits", i), 64'(w), 64'(e.waits));
      chk($sformatf("v%0d_ctrl", i), 64'(csr_ctrl), 64'(tv[i].ctrl));
      chk($sformatf("v%0d_timing", i), 64'(csr_timing), 64'(tv[i].timing));
      chk($sformatf("v%0d_tref", i), 64'(csr_tref), 64'(tv[i].tref));
      chk($sformatf("v%0d_cfg", i), port_cfg, tv[i].cfg);
    end
    ack_dly = -1;
    apb(1, 6'h04, 32'h5555_AAAA, 4'hF, 3'b000, rd, err, w);
    chk("to_err", 64'(err), 64'd1);
    chk("to_waits", 64'(w), 64'(TO + 1));
    chk("to_timing_kept", 64'(csr_timing), 64'hAAAA_5678);
    ack_force = 1;
    repeat (3) @(negedge PCLK);
    chk("stray_ack_req", 64'(upd_req), 64'd0);
    chk("stray_ack_timing", 64'(csr_timing), 64'hAAAA_5678);
    ack_force = 0;
    apb(0, 6'h0C, 32'h0, 4'hF, 3'b000, rd, err, w);
    chk("stray_ack_status", 64'(rd), 64'h6);
    ack_dly = 0;
`ifdef SDRAM_CSR_PROT_EN
    apb(1, 6'h00, 32'h2000_0000, 4'hF, 3'b001, rd, err, w);
    chk("prot_set_err", 64'(err), 64'd0);
    chk("prot_set_ctrl", 64'(csr_ctrl), 64'h2000_0000);
    chk("prot_set_timing", 64'(csr_timing), 64'h5555_AAAA);
    apb(1, 6'h04, 32'h0BAD_F00D, 4'hF, 3'b000, rd, err, w);
    chk("prot_user_wr_err", 64'(err), 64'd1);
    chk("prot_user_wr_waits", 64'(w), 64'd0);
    chk("prot_user_wr_timing", 64'(csr_timing), 64'h5555_AAAA);
    apb(0, 6'h04, 32'h0, 4'hF, 3'b000, rd, err, w);
    chk("prot_user_rd_err", 64'(err), 64'd1);
    apb(0, 6'h04, 32'h0, 4'hF, 3'b001, rd, err, w);
    chk("prot_priv_rd_err", 64'(err), 64'd0);
    chk("prot_priv_rd", 64'(rd), 64'h5555_AAAA);
`else
    apb(1, 6'h00, 32'h2000_0000, 4'hF, 3'b000, rd, err, w);
    chk("noprot_wr_err", 64'(err), 64'd0);
    chk("noprot_ctrl", 64'(csr_ctrl), 64'd0);
    chk("noprot_timing", 64'(csr_timing), 64'h5555_AAAA);
    apb(0, 6'h00, 32'h0, 4'hF, 3'b000, rd, err, w);
    chk("noprot_ctrl_rd", 64'(rd), 64'h4000_0000);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
